mux_route_loader: RTL and testbench
===================================

# mux_route_loader

Configuration writer for the pin crossbar. It accepts a byte stream of routing commands over a valid/ready handshake, typically fed from the host UART receiver, and stages them in a shadow routing table. On a commit command it atomically drives the crossbar's packed `selectors` and `enabled_out` buses. It also reports per-command completion and errors, and aborts stalled partial commands on an inter-byte timeout.

## Interface
- `INPUT_COUNT`, 16: crossbar source count; 2..256.
- `OUTPUT_COUNT`, 16: crossbar output count; 1..256.
- `TIMEOUT_CYCLES`, 1000000: idle cycles allowed between bytes of one command; 0 disables the timeout.
- `SEL_WIDTH` (localparam) = $clog2(INPUT_COUNT).

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  command byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a byte.
- `selectors`  out  SEL_WIDTH*OUTPUT_COUNT  active table; field i = bits [(i+1)*SEL_WIDTH-1 : i*SEL_WIDTH] is the source index for output i.
- `enabled_out`  out  OUTPUT_COUNT  active enable per output.
- `cmd_done`  out  1  one-cycle pulse: command executed.
- `cmd_err`  out  1  one-cycle pulse: command rejected.
- `err_code`  out  2  cause, valid with `cmd_err`: 1 bad opcode, 2 index out of range, 3 timeout. Holds the last code until the next `cmd_err`.

## Operation
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- Opcodes, each first byte of a command:
  - 0x01 SET: then OUT byte, then SRC byte. Shadow selector[OUT] = SRC; shadow enable[OUT] = 1.
  - 0x02 DISABLE: then OUT byte. Shadow enable[OUT] = 0; selector unchanged.
  - 0x03 COMMIT: copy the whole shadow table to `selectors` and `enabled_out` in one edge.
  - 0x04 CLEAR: shadow selectors = 0 and shadow enables = 0. Active outputs are unchanged.
  - Any other opcode gives `cmd_err`, code 1. The byte is dropped and the FSM stays in IDLE.
- Range checks, done in EXEC:
  - OUT >= OUTPUT_COUNT or SRC >= INPUT_COUNT gives code 2, with no shadow write.
  - SRC is stored truncated to SEL_WIDTH only after the check passes.
- FSM states: IDLE, ARG1, ARG2, EXEC.
  - IDLE: on 0x01 or 0x02 go to ARG1; on 0x03 or 0x04 go to EXEC; on an invalid opcode stay in IDLE.
  - ARG1: on a byte, latch OUT; go to ARG2 if SET, EXEC if DISABLE.
  - ARG2: on a byte, latch SRC; go to EXEC.
  - EXEC: one cycle; perform the write/commit or flag an error; go to IDLE.
- `in_ready` = 1 in IDLE, ARG1 and ARG2; 0 in EXEC and while `rst` is high.
- Timeout:
  - The counter increments each cycle in ARG1 or ARG2 with no accepted byte.
  - It clears on an accepted byte or on entry to IDLE.
  - At TIMEOUT_CYCLES it forces IDLE and pulses `cmd_err` with code 3. The partial command is discarded.
  - If a byte is accepted on the same edge the count would expire, the byte wins.
- `cmd_done` and `cmd_err` are never high together.

## Timing
- Reset values:
  - Active and shadow selectors = 0; active and shadow enables = 0, so all crossbar outputs are hi-Z.
  - FSM in IDLE, counter = 0, `cmd_done` = 0, `cmd_err` = 0, `err_code` = 0, `in_ready` = 0 while reset is asserted.
- Reset mid-command discards the partial command. Shadow and active tables return to reset values.
- Execution latency: last byte accepted at edge N → EXEC during cycle N..N+1 → table write, commit and `cmd_done`/`cmd_err` at edge N+1. `in_ready` rises again at edge N+1.
- Bad opcode: the byte is accepted at edge N and `cmd_err` is high N..N+1. `in_ready` stays high, so back-to-back bytes are accepted.
- Maximum throughput: a SET takes 4 cycles; COMMIT and CLEAR take 2 cycles.
- `selectors` and `enabled_out` change only on a COMMIT edge or on reset. No partially updated table is ever visible.

## Test plan
- Reset, then SET 0x01,0x00,0x0F followed by COMMIT 0x03 → `cmd_done` pulses twice; afterwards `selectors[3:0]`=15 and `enabled_out`=0x0001.
- SET 0x01,0x05,0x02 with no COMMIT → `selectors` and `enabled_out` remain 0; a following 0x03 makes field 5 = 2 and `enabled_out`=0x0020 on one edge.
- Send 0x07 → `cmd_err` with `err_code`=1, no state change. Then SET 0x01,0x10,0x00 with OUTPUT_COUNT=16 → `err_code`=2, and a subsequent COMMIT changes nothing.
- With TIMEOUT_CYCLES=8, send 0x01,0x02 then hold `in_valid` low → `cmd_err`, `err_code`=3, 8 cycles after the OUT byte. A fresh 0x03 then succeeds.
- Commit routes for outputs 0 and 1, then CLEAR 0x04 → active tables unchanged; a later COMMIT drives `enabled_out`=0.
- Assert `rst` after 0x01,0x03 has been accepted → outputs return to reset values immediately. After release, a new 0x03 commits an all-zero table.

Source files
------------

// File: rtl/mux_route_loader.sv
// mux_route_loader: byte-command loader that stages a shadow crossbar routing table
// and drives the active selectors/enables only on a commit command.
module mux_route_loader #(
    parameter int INPUT_COUNT    = 16,
    parameter int OUTPUT_COUNT   = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int SEL_WIDTH     = $clog2(INPUT_COUNT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [SEL_WIDTH*OUTPUT_COUNT-1:0] selectors,
    output logic [OUTPUT_COUNT-1:0]           enabled_out,
    output logic                              cmd_done,
    output logic                              cmd_err,
    output logic [1:0]                        err_code
);
    localparam int OW = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ARG1, ARG2, EXEC} state_t;

    state_t                                 state, next;
    logic [1:0]                             op;
    logic [7:0]                             out_idx, src;
    logic [CW-1:0]                          cnt;
    logic [OUTPUT_COUNT-1:0][SEL_WIDTH-1:0] shadow_sel;
    logic [OUTPUT_COUNT-1:0]                shadow_en;
    logic                                   accept, waiting, expire, op_ok, bad_op, range_bad, exec_ok;

    // op holds the low opcode bits: 1 SET, 2 DISABLE, 3 COMMIT, 0 CLEAR
    assign in_ready  = state != EXEC && !rst;
    assign accept    = in_valid && in_ready;
    assign waiting   = state == ARG1 || state == ARG2;
    assign expire    = TIMEOUT_CYCLES != 0 && waiting && !accept && cnt == T_LAST;
    assign op_ok     = in_data >= 8'h01 && in_data <= 8'h04;
    assign bad_op    = state == IDLE && accept && !op_ok;
    assign range_bad = (op == 2'd1 || op == 2'd2) &&
                       (int'(out_idx) >= OUTPUT_COUNT || (op == 2'd1 && int'(src) >= INPUT_COUNT));
    assign exec_ok   = state == EXEC && !range_bad;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (!accept || !op_ok) ? IDLE : (in_data == 8'h01 || in_data == 8'h02) ? ARG1 : EXEC;
            ARG1:    next = accept ? ((op == 2'd1) ? ARG2 : EXEC) : expire ? IDLE : ARG1;
            ARG2:    next = accept ? EXEC : expire ? IDLE : ARG2;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op          <= '0;
            out_idx     <= '0;
            src         <= '0;
            cnt         <= '0;
            shadow_sel  <= '0;
            shadow_en   <= '0;
            selectors   <= '0;
            enabled_out <= '0;
            cmd_done    <= 1'b0;
            cmd_err     <= 1'b0;
            err_code    <= 2'd0;
        end else begin
            state    <= next;
            cnt      <= (accept || next == IDLE) ? '0 : waiting ? cnt + CW'(1) : cnt;
            cmd_done <= exec_ok;
            cmd_err  <= bad_op || expire || (state == EXEC && range_bad);
            if (state == IDLE && accept) op <= in_data[1:0];
            if (state == ARG1 && accept) out_idx <= in_data;
            if (state == ARG2 && accept) src <= in_data;
            if (bad_op) err_code <= 2'd1;
            else if (expire) err_code <= 2'd3;
            else if (state == EXEC && range_bad) err_code <= 2'd2;
            if (exec_ok && op == 2'd1) begin
                shadow_sel[out_idx[OW-1:0]] <= src[SEL_WIDTH-1:0];
                shadow_en[out_idx[OW-1:0]]  <= 1'b1;
            end
            if (exec_ok && op == 2'd2) shadow_en[out_idx[OW-1:0]] <= 1'b0;
            if (exec_ok && op == 2'd3) begin
                selectors   <= shadow_sel;
                enabled_out <= shadow_en;
            end
            if (exec_ok && op == 2'd0) begin
                shadow_sel <= '0;
                shadow_en  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mux_route_loader.sv
// tb_mux_route_loader: randomized command stream against a table-level reference model,
// with a scoreboard queue popped by an independent monitor on every cmd_done/cmd_err pulse.
module tb_mux_route_loader;
    localparam int IC = 16, OC = 16, TO = 8, SW = 4;

    logic           clk = 1'b0, rst = 1'b1;
    logic [7:0]     in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [SW*OC-1:0] selectors;
    logic [OC-1:0]  enabled_out;
    logic           cmd_done, cmd_err;
    logic [1:0]     err_code;
    int             checks = 0, errors = 0;

    typedef struct {
        bit               err;
        int               code;
        logic [SW*OC-1:0] sel;
        logic [OC-1:0]    en;
    } exp_t;

    exp_t sb[$];
    int   sh_sel[OC], sh_en[OC], act_sel[OC], act_en[OC];
    int   last_code;

    mux_route_loader #(.INPUT_COUNT(IC), .OUTPUT_COUNT(OC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .selectors(selectors), .enabled_out(enabled_out), .cmd_done(cmd_done),
        .cmd_err(cmd_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [SW*OC-1:0] pack_sel();
        logic [SW*OC-1:0] v;
        v = '0;
        for (int i = 0; i < OC; i++) v[i*SW +: SW] = SW'(act_sel[i]);
        return v;
    endfunction

    function automatic logic [OC-1:0] pack_en();
        logic [OC-1:0] v;
        v = '0;
        for (int i = 0; i < OC; i++) v[i] = act_en[i] != 0;
        return v;
    endfunction

    task automatic model_reset();
        sh_sel = '{default: 0};
        sh_en = '{default: 0};
        act_sel = '{default: 0};
        act_en = '{default: 0};
        last_code = 0;
    endtask

    task automatic push(bit err, int code);
        exp_t e;
        if (err) last_code = code;
        e.err = err;
        e.code = last_code;
        e.sel = pack_sel();
        e.en = pack_en();
        sb.push_back(e);
    endtask

    task automatic send(int b, int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_data = 8'(b);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake in_ready stuck low got 0 want 1");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic cmd_set(int o, int s, int gap);
        send(1, gap);
        send(o, gap);
        send(s, gap);
        if (o >= OC || s >= IC) push(1, 2);
        else begin
            sh_sel[o] = s;
            sh_en[o] = 1;
            push(0, 0);
        end
    endtask

    task automatic cmd_dis(int o, int gap);
        send(2, gap);
        send(o, gap);
        if (o >= OC) push(1, 2);
        else begin
            sh_en[o] = 0;
            push(0, 0);
        end
    endtask

    task automatic cmd_commit(int gap);
        send(3, gap);
        act_sel = sh_sel;
        act_en = sh_en;
        push(0, 0);
    endtask

    task automatic cmd_clear(int gap);
        send(4, gap);
        sh_sel = '{default: 0};
        sh_en = '{default: 0};
        push(0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending responses got %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (cmd_done || cmd_err) begin
                check("done_err_exclusive", 64'(cmd_done & cmd_err), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse got done=%0d err=%0d want none", cmd_done, cmd_err);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind_err", 64'(cmd_err), 64'(e.err));
                    check("err_code", 64'(err_code), 64'(e.code));
                    check("selectors", 64'(selectors), 64'(e.sel));
                    check("enabled_out", 64'(enabled_out), 64'(e.en));
                end
            end
        end
    end

    initial begin : stimulus
        int lat, r, b;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_selectors", 64'(selectors), 0);
        check("rst_enabled", 64'(enabled_out), 0);
        check("rst_done", 64'(cmd_done), 0);
        check("rst_err", 64'(cmd_err), 0);
        check("rst_err_code", 64'(err_code), 0);
        rst = 1'b0;

        cmd_set(0, 15, 0);
        cmd_commit(0);
        drain();
        check("t1_field0", 64'(selectors[3:0]), 15);
        check("t1_enabled", 64'(enabled_out), 64'h0001);

        cmd_set(5, 2, 0);
        drain();
        check("t2_no_commit_enabled", 64'(enabled_out), 64'h0001);
        cmd_commit(0);
        drain();
        check("t2_field5", 64'(selectors[23:20]), 2);
        check("t2_enabled", 64'(enabled_out), 64'h0021);

        send(8'h07, 0);
        push(1, 1);
        @(negedge clk);
        check("bad_op_in_ready", 64'(in_ready), 1);
        cmd_set(16, 0, 0);
        cmd_commit(0);
        drain();

        send(1, 0);
        send(2, 0);
        push(1, 3);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (cmd_err) begin
                lat = i;
                break;
            end
        end
        check("timeout_latency", 64'(lat), 8);
        cmd_commit(0);
        drain();

        cmd_set(0, 3, 0);
        cmd_set(1, 4, 0);
        cmd_commit(0);
        cmd_clear(0);
        drain();
        check("clear_keeps_active_en0", 64'(enabled_out[0]), 1);
        cmd_commit(0);
        drain();
        check("clear_commit_enabled", 64'(enabled_out), 0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            lat = $urandom_range(0, 2);
            if (r <= 3) cmd_set($urandom_range(0, 19), $urandom_range(0, 19), lat);
            else if (r <= 5) cmd_dis($urandom_range(0, 19), lat);
            else if (r <= 7) cmd_commit(lat);
            else if (r == 8) cmd_clear(lat);
            else begin
                b = $urandom_range(0, 255);
                if (b >= 1 && b <= 4) b = 0;
                send(b, lat);
                push(1, 1);
            end
        end
        drain();

        cmd_set(2, 9, 0);
        cmd_commit(0);
        drain();
        send(1, 0);
        send(3, 0);
        rst = 1'b1;
        #1;
        check("midrst_selectors", 64'(selectors), 0);
        check("midrst_enabled", 64'(enabled_out), 0);
        check("midrst_in_ready", 64'(in_ready), 0);
        check("midrst_err_code", 64'(err_code), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmd_commit(0);
        drain();
        check("midrst_commit_enabled", 64'(enabled_out), 0);

        check("scoreboard_empty", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
